// File: rtl/fifo_unpacker_if.sv
// rtl/fifo_unpacker_if.sv - FIFO drain side and beat stream of the unpacker
interface fifo_unpacker_if #(
    parameter int DW = 64,
    parameter int OW = 8
);
    logic          fifo_empty;
    logic [DW-1:0] data_pop;
    logic          fifo_pop;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic          out_ready;

    modport master (
        input  fifo_empty,
        input  data_pop,
        input  out_ready,
        output fifo_pop,
        output out_valid,
        output out_data,
        output out_last
    );

    modport slave (
        output fifo_empty,
        output data_pop,
        output out_ready,
        input  fifo_pop,
        input  out_valid,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/fifo_unpacker.sv
// rtl/fifo_unpacker.sv - pops DW-bit FIFO entries and streams them as OW-bit beats, LSB beat first
module fifo_unpacker #(
    parameter int DW = 64,
    parameter int OW = 8
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             flush,
    output logic             busy,
    fifo_unpacker_if.master  bus
);
    localparam int NB = DW / OW;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        state;
    logic [DW-1:0] shreg;
    logic [CW-1:0] cnt;
    logic          last;
    logic          accept;
    logic          load;

    assign last   = (state == SEND) && (cnt == CW'(NB - 1));
    assign accept = (state == SEND) && bus.out_ready && !flush;

    // Reload on the last-beat handshake so consecutive entries leave no bubble.
    assign load = RSTn && !flush && !bus.fifo_empty &&
                  ((state == IDLE) || (bus.out_ready && last));

    assign bus.fifo_pop  = load;
    assign bus.out_valid = (state == SEND);
    assign bus.out_data  = shreg[OW-1:0];
    assign bus.out_last  = last;
    assign busy          = (state == SEND);

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (load) begin
            shreg <= bus.data_pop;
            cnt   <= '0;
            state <= SEND;
        end else if (accept) begin
            if (last) begin
                state <= IDLE;
            end else begin
                shreg <= shreg >> OW;
                cnt   <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: doc/fifo_unpacker.md
# fifo_unpacker

Downstream drain stage for the generic FIFO (`gen_fifo`). It pops one DW-bit entry at a time and serializes it into OW-bit beats, least-significant beat first, on a valid/ready stream. Typical use is feeding an 8-bit console or debug sink in the verification top. When the FIFO stays non-empty, consecutive entries are sent with no idle bubble.

## Interface
Parameters:
- `DW`, 64, width of a FIFO entry; must be an integer multiple of `OW`.
- `OW`, 8, output beat width.
- `NB` (localparam), `DW/OW`, beats per entry. `CW = max(1, clog2(NB))` is the beat-counter width.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RSTn`  in  1  reset, synchronous and active-low.
- `fifo_empty`  in  1  FIFO empty flag.
- `data_pop`  in  DW  FIFO head entry; combinational from the FIFO read pointer.
- `fifo_pop`  out  1  pop strobe to the FIFO; combinational.
- `out_valid`  out  1  beat valid.
- `out_data`  out  OW  beat payload.
- `out_last`  out  1  final beat of the current entry.
- `out_ready`  in  1  sink accepts the beat.
- `busy`  out  1  entry in flight; equal to `state == SEND`.
- `flush`  in  1  abort; shares its meaning with the FIFO flush.

## Operation
- State machine with two states, IDLE and SEND. Registers:
  - `state`
  - `shreg[DW-1:0]`
  - `cnt[CW-1:0]`
- `load = ~flush & ~fifo_empty & ((state==IDLE) | (state==SEND & out_ready & out_last))`.
- `fifo_pop = load`. It is forced to 0 while `RSTn == 0`.
- On `load`:
  - `shreg <= data_pop`, `cnt <= 0`, `state <= SEND`.
  - The FIFO advances its read pointer on the same edge, so the latched data is the entry being popped.
- In SEND:
  - `out_valid = 1`.
  - `out_data = shreg[OW-1:0]`.
  - `out_last = (cnt == NB-1)`.
- Beat accepted (`out_valid & out_ready`) with `~out_last`: `shreg <= shreg >> OW`, `cnt <= cnt + 1`.
- Beat accepted with `out_last`:
  - If `load` is true, reload the next entry (back-to-back).
  - Otherwise `state <= IDLE`.
- In IDLE:
  - `out_valid = 0`, `out_last = 0`.
  - `out_data` holds the current `shreg[OW-1:0]`; it is don't-care for the sink.
- `flush` has priority over everything:
  - Next state is IDLE, `cnt <= 0`.
  - No pop is issued in the flush cycle.
  - A beat presented in the flush cycle counts as not transferred, even if `out_ready` is 1.
  - The partially sent entry is dropped.
- `out_valid`, once raised, holds with stable `out_data` until accepted (AXI-stream rule). The only exceptions are flush and reset.
- `cnt` arithmetic is modulo `2^CW`. It never exceeds `NB-1`. When `NB == 1`, `out_last` is constantly 1 in SEND.

## Timing
- Reset (`RSTn` low at an edge):
  - `state = IDLE`, `shreg = 0`, `cnt = 0`.
  - So `out_valid = 0`, `out_data = 0`, `out_last = 0`, `busy = 0`, `fifo_pop = 0`.
  - Reset mid-entry discards the entry. The FIFO is expected to be reset or flushed alongside.
- Latency from an IDLE cycle with `fifo_empty = 0` (`fifo_pop = 1`) to first `out_valid` is 1 cycle.
- Throughput is NB cycles per entry when `out_ready` is held high. There is no gap between the last beat of entry k and the first beat of entry k+1 if the FIFO is non-empty at the last-beat handshake.
- When `out_ready` is low, the beat and `cnt` hold. `fifo_pop` stays 0 even on the last beat.
- When FIFO empty coincides with the last-beat handshake, the next cycle is IDLE. A later `fifo_empty` deassertion pops on that same cycle.
- When flush coincides with a last-beat handshake and `fifo_empty = 0`, no pop occurs and the next state is IDLE.
- `fifo_pop` must never be asserted while `fifo_empty = 1`.

## Test plan
- Reset behaviour: hold `RSTn = 0` with `fifo_empty = 0` and `out_ready = 1`.
  - Required: `fifo_pop`, `out_valid` and `busy` stay 0, and `out_data` is 0.
  - After release, the first pop occurs on the next cycle.
- Single entry: push `0x0807060504030201` with `out_ready` held at 1.
  - Required: beats 01, 02 … 08 on 8 consecutive cycles.
  - `out_last` is asserted only on 08.
  - Exactly one `fifo_pop`; then IDLE with `out_valid = 0`.
- Back-to-back: push 3 entries `0x11…11`, `0x22…22`, `0x33…33`.
  - Required: 24 consecutive valid cycles with no bubble.
  - `fifo_pop` is high in cycle 0 and on the last-beat cycles 8 and 16.
- Backpressure: deassert `out_ready` randomly during an entry.
  - Required: the beat sequence is unchanged and `out_data` is stable while `out_valid & ~out_ready`.
  - On the last beat with `out_ready = 0`, `fifo_pop` stays 0.
- Flush: assert `flush` after beat 3 of entry `0xAA..`, with entry `0xBB..` still queued and `flush` also driven to the FIFO.
  - Required: the next cycle has `out_valid = 0` and `busy = 0`.
  - No beats of `0xBB..` are sent unless it is pushed again.
- Empty at last beat: push one entry, then a second entry 2 cycles after its last beat.
  - Required: exactly 2 IDLE cycles between the entries and no pop while empty.
